// File: rtl/m2vcoefbuf_pkg.sv
// m2vcoefbuf shared types and scan tables.
// Scan tables map scan position to raster index.
package m2vcoefbuf_pkg;

  localparam int DEF_COEF_WIDTH = 12;
  localparam int DEF_RUN_WIDTH  = 6;

  typedef struct packed {
    logic                      sign;
    logic [DEF_COEF_WIDTH-1:0] mag;
  } coef_t;

  typedef enum logic {
    RD_IDLE,
    RD_ACTIVE
  } rd_state_t;

  localparam logic [5:0] ZIGZAG_SCAN [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10,
    17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34,
    27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36,
    29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46,
    53, 60, 61, 54, 47, 55, 62, 63
  };

  localparam logic [5:0] ALT_SCAN [64] = '{
     0,  8, 16, 24,  1,  9,  2, 10,
    17, 25, 32, 40, 48, 56, 57, 49,
    41, 33, 26, 18,  3, 11,  4, 12,
    19, 27, 34, 42, 50, 58, 35, 43,
    51, 59, 20, 28,  5, 13,  6, 14,
    21, 29, 36, 44, 52, 60, 37, 45,
    53, 61, 22, 30,  7, 15, 23, 31,
    38, 46, 54, 62, 39, 47, 55, 63
  };

endpackage

// File: rtl/m2vcoefbuf_if.sv
// VLD write port and IDCT read port of the coef buffer.
// master = producer/consumer side, slave = buffer.
interface m2vcoefbuf_if
  import m2vcoefbuf_pkg::*;
#(
  parameter int COEF_WIDTH = DEF_COEF_WIDTH,
  parameter int RUN_WIDTH  = DEF_RUN_WIDTH
);

  logic                  rl_valid;
  logic                  rl_ready;
  logic                  rl_eob;
  logic [RUN_WIDTH-1:0]  rl_run;
  logic                  rl_sign;
  logic [COEF_WIDTH-1:0] rl_level;
  logic                  alt_scan;
  logic                  blk_ready;
  logic                  blk_coded;
  logic                  block_start;
  logic                  coef_next;
  logic                  coef_sign;
  logic [COEF_WIDTH-1:0] coef_data;
  logic                  err;

  modport master (
    output rl_valid, rl_eob, rl_run,
    output rl_sign, rl_level, alt_scan,
    output block_start, coef_next,
    input  rl_ready, blk_ready, blk_coded,
    input  coef_sign, coef_data, err
  );

  modport slave (
    input  rl_valid, rl_eob, rl_run,
    input  rl_sign, rl_level, alt_scan,
    input  block_start, coef_next,
    output rl_ready, blk_ready, blk_coded,
    output coef_sign, coef_data, err
  );

endinterface

// File: rtl/m2vscan_rom.sv
// Scan position to raster index lookup.
// Purely combinational; alt selects alternate scan.
module m2vscan_rom
  import m2vcoefbuf_pkg::*;
(
  input  logic       alt,
  input  logic [5:0] scan_idx,
  output logic [5:0] raster_idx
);

  always_comb begin
    raster_idx = alt ? ALT_SCAN[scan_idx]
                     : ZIGZAG_SCAN[scan_idx];
  end

endmodule

// File: rtl/m2vcoefbuf.sv
// Double-banked de-scan buffer between VLD and IDCT.
// Written mask makes unwritten entries read as zero.
module m2vcoefbuf
  import m2vcoefbuf_pkg::*;
#(
  parameter int COEF_WIDTH = DEF_COEF_WIDTH,
  parameter int RUN_WIDTH  = DEF_RUN_WIDTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         softreset,
  m2vcoefbuf_if.slave  bus
);

  localparam int EW = COEF_WIDTH + 1;

  logic [EW-1:0]         mem [2][64];
  logic [63:0]           mask [2];
  logic [1:0]            full;
  logic                  wr;
  logic                  rd;
  logic [6:0]            pos;
  logic                  alt_q;
  logic [5:0]            ridx;
  logic                  err_q;
  logic                  sign_q;
  logic [COEF_WIDTH-1:0] data_q;
  rd_state_t             st;
  rd_state_t             st_nx;

  logic                  accept;
  logic [6:0]            p;
  logic                  alt_eff;
  logic                  wr_ok;
  logic                  wr_ovf;
  logic                  wr_eob;
  logic [5:0]            w_raster;
  logic                  start_ok;
  logic                  step;
  logic                  rel;
  logic [5:0]            rd_idx_nx;
  logic [EW-1:0]         rd_ent;

  assign bus.rl_ready  = !full[wr];
  assign bus.blk_ready = full[rd];
  assign bus.blk_coded = |mask[rd];
  assign bus.coef_sign = sign_q;
  assign bus.coef_data = data_q;
  assign bus.err       = err_q;

  always_comb begin
    accept  = bus.rl_valid & !full[wr];
    p       = pos + 7'(bus.rl_run);
    // scan type is latched by the first pair of a block
    alt_eff = (pos == 7'd0) ? bus.alt_scan : alt_q;
    wr_ok   = accept & !bus.rl_eob & !p[6];
    wr_ovf  = accept & !bus.rl_eob & p[6];
    wr_eob  = accept & bus.rl_eob;
  end

  m2vscan_rom u_rom (
    .alt        (alt_eff),
    .scan_idx   (p[5:0]),
    .raster_idx (w_raster)
  );

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr][w_raster] <= {bus.rl_sign, bus.rl_level};
    end
  end

  always_comb begin
    st_nx    = st;
    start_ok = 1'b0;
    step     = 1'b0;
    rel      = 1'b0;
    unique case (st)
      RD_IDLE: begin
        if (bus.block_start && full[rd]) begin
          start_ok = 1'b1;
          st_nx    = RD_ACTIVE;
        end
      end
      RD_ACTIVE: begin
        if (bus.coef_next) begin
          if (ridx == 6'd63) begin
            rel   = 1'b1;
            st_nx = RD_IDLE;
          end else begin
            step = 1'b1;
          end
        end
      end
      default: st_nx = RD_IDLE;
    endcase
  end

  always_comb begin
    rd_idx_nx = start_ok ? 6'd0 : ridx + 6'd1;
    rd_ent    = mask[rd][rd_idx_nx] ? mem[rd][rd_idx_nx]
                                    : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st <= RD_IDLE;
    end else if (softreset) begin
      st <= RD_IDLE;
    end else begin
      st <= st_nx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full   <= '0;
      mask   <= '{default: '0};
      wr     <= 1'b0;
      rd     <= 1'b0;
      pos    <= '0;
      alt_q  <= 1'b0;
      ridx   <= '0;
      err_q  <= 1'b0;
      sign_q <= 1'b0;
      data_q <= '0;
    end else if (softreset) begin
      full   <= '0;
      mask   <= '{default: '0};
      wr     <= 1'b0;
      rd     <= 1'b0;
      pos    <= '0;
      alt_q  <= 1'b0;
      ridx   <= '0;
      err_q  <= 1'b0;
      sign_q <= 1'b0;
      data_q <= '0;
    end else begin
      if (accept && !bus.rl_eob && pos == 7'd0) begin
        alt_q <= bus.alt_scan;
      end
      if (wr_ok) begin
        pos <= p + 7'd1;
      end
      if (wr_ovf) begin
        pos   <= 7'd64;
        err_q <= 1'b1;
      end
      if (wr_eob) begin
        pos <= '0;
        wr  <= ~wr;
      end
      if (start_ok || step) begin
        ridx   <= rd_idx_nx;
        sign_q <= rd_ent[EW-1];
        data_q <= rd_ent[COEF_WIDTH-1:0];
      end else if (rel) begin
        rd     <= ~rd;
        sign_q <= 1'b0;
        data_q <= '0;
      end
      // write and release never target the same bank
      for (int b = 0; b < 2; b++) begin
        if (rel && rd == 1'(b)) begin
          full[b] <= 1'b0;
          mask[b] <= '0;
        end else begin
          if (wr_eob && wr == 1'(b)) begin
            full[b] <= 1'b1;
          end
          if (wr_ok && wr == 1'(b)) begin
            mask[b][w_raster] <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_m2vcoefbuf.sv
// Directed bench for m2vcoefbuf.
// Each scenario task carries its own expected values.
module tb_m2vcoefbuf;
  import m2vcoefbuf_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic softreset;
  int   n_cmp = 0;
  int   n_bad = 0;

  coef_t got [64];
  coef_t exp_c [64];

  always #5 clk = ~clk;

  m2vcoefbuf_if bus ();

  m2vcoefbuf dut (
    .clk       (clk),
    .reset     (reset),
    .softreset (softreset),
    .bus       (bus)
  );

  task automatic send(input logic eob, input int run,
                      input logic sgn, input int lvl,
                      input logic alt);
    int n;
    @(negedge clk);
    bus.rl_valid = 1'b1;
    bus.rl_eob   = eob;
    bus.rl_run   = 6'(run);
    bus.rl_sign  = sgn;
    bus.rl_level = 12'(lvl);
    bus.alt_scan = alt;
    n = 0;
    while (!bus.rl_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout rl_ready got 0 want 1");
    end
    @(negedge clk);
    bus.rl_valid = 1'b0;
    bus.rl_eob   = 1'b0;
  endtask

  task automatic read_block();
    int n;
    n = 0;
    while (!bus.blk_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_cmp++;
      n_bad++;
      $display("FAIL read_timeout blk_ready got 0 want 1");
    end
    bus.block_start = 1'b1;
    @(negedge clk);
    bus.block_start = 1'b0;
    for (int i = 0; i < 64; i++) begin
      got[i] = coef_t'({bus.coef_sign, bus.coef_data});
      bus.coef_next = 1'b1;
      @(negedge clk);
      bus.coef_next = 1'b0;
    end
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({bus.rl_ready, bus.blk_ready, bus.blk_coded} !== 3'b100) begin
      n_bad++;
      $display("FAIL rst_flags got %b want 100",
        {bus.rl_ready, bus.blk_ready, bus.blk_coded});
    end
    n_cmp++;
    if ({bus.coef_sign, bus.coef_data, bus.err} !== 14'h0) begin
      n_bad++;
      $display("FAIL rst_outs got %h want 0",
        {bus.coef_sign, bus.coef_data, bus.err});
    end
    bus.block_start = 1'b1;
    bus.coef_next   = 1'b1;
    @(negedge clk);
    bus.block_start = 1'b0;
    bus.coef_next   = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.blk_ready, bus.coef_data} !== 13'h0) begin
      n_bad++;
      $display("FAIL rst_ignore got %h want 0",
        {bus.blk_ready, bus.coef_data});
    end
  endtask

  task automatic test_zigzag();
    send(1'b0, 0, 1'b0, 5, 1'b0);
    send(1'b0, 1, 1'b1, 3, 1'b0);
    send(1'b1, 0, 1'b0, 0, 1'b0);
    n_cmp++;
    if ({bus.blk_ready, bus.blk_coded} !== 2'b11) begin
      n_bad++;
      $display("FAIL zz_flags got %b want 11",
        {bus.blk_ready, bus.blk_coded});
    end
    exp_c = '{default: '0};
    exp_c[0] = '{sign: 1'b0, mag: 12'd5};
    exp_c[8] = '{sign: 1'b1, mag: 12'd3};
    read_block();
    for (int i = 0; i < 64; i++) begin
      n_cmp++;
      if (got[i] !== exp_c[i]) begin
        n_bad++;
        $display("FAIL zz_coef[%0d] got %h want %h",
          i, got[i], exp_c[i]);
      end
    end
    n_cmp++;
    if ({bus.blk_ready, bus.coef_data} !== 13'h0) begin
      n_bad++;
      $display("FAIL zz_done got %h want 0",
        {bus.blk_ready, bus.coef_data});
    end
  endtask

  task automatic test_alt();
    send(1'b0, 0, 1'b0, 5, 1'b1);
    send(1'b0, 1, 1'b1, 3, 1'b1);
    send(1'b1, 0, 1'b0, 0, 1'b1);
    exp_c = '{default: '0};
    exp_c[0]  = '{sign: 1'b0, mag: 12'd5};
    exp_c[16] = '{sign: 1'b1, mag: 12'd3};
    read_block();
    for (int i = 0; i < 64; i++) begin
      n_cmp++;
      if (got[i] !== exp_c[i]) begin
        n_bad++;
        $display("FAIL alt_coef[%0d] got %h want %h",
          i, got[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    send(1'b0, 0, 1'b0, 9, 1'b0);
    send(1'b1, 0, 1'b0, 0, 1'b0);
    send(1'b0, 2, 1'b1, 4, 1'b0);
    send(1'b1, 0, 1'b0, 0, 1'b0);
    n_cmp++;
    if ({bus.rl_ready, bus.blk_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL b2b_full got %b want 01",
        {bus.rl_ready, bus.blk_ready});
    end
    exp_c = '{default: '0};
    exp_c[0] = '{sign: 1'b0, mag: 12'd9};
    read_block();
    for (int i = 0; i < 64; i++) begin
      n_cmp++;
      if (got[i] !== exp_c[i]) begin
        n_bad++;
        $display("FAIL b2b_a[%0d] got %h want %h",
          i, got[i], exp_c[i]);
      end
    end
    n_cmp++;
    if ({bus.rl_ready, bus.blk_ready} !== 2'b11) begin
      n_bad++;
      $display("FAIL b2b_release got %b want 11",
        {bus.rl_ready, bus.blk_ready});
    end
    exp_c = '{default: '0};
    exp_c[8] = '{sign: 1'b1, mag: 12'd4};
    read_block();
    for (int i = 0; i < 64; i++) begin
      n_cmp++;
      if (got[i] !== exp_c[i]) begin
        n_bad++;
        $display("FAIL b2b_b[%0d] got %h want %h",
          i, got[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_overflow();
    send(1'b0, 0, 1'b0, 1, 1'b0);
    send(1'b0, 63, 1'b0, 7, 1'b0);
    send(1'b1, 0, 1'b0, 0, 1'b0);
    n_cmp++;
    if (bus.err !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_err got %b want 1", bus.err);
    end
    exp_c = '{default: '0};
    exp_c[0] = '{sign: 1'b0, mag: 12'd1};
    read_block();
    for (int i = 0; i < 64; i++) begin
      n_cmp++;
      if (got[i] !== exp_c[i]) begin
        n_bad++;
        $display("FAIL ovf_coef[%0d] got %h want %h",
          i, got[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_empty();
    send(1'b1, 0, 1'b0, 0, 1'b0);
    n_cmp++;
    if ({bus.blk_ready, bus.blk_coded} !== 2'b10) begin
      n_bad++;
      $display("FAIL empty_flags got %b want 10",
        {bus.blk_ready, bus.blk_coded});
    end
    read_block();
    for (int i = 0; i < 64; i++) begin
      n_cmp++;
      if (got[i] !== '0) begin
        n_bad++;
        $display("FAIL empty_coef[%0d] got %h want 0",
          i, got[i]);
      end
    end
    n_cmp++;
    if (bus.err !== 1'b1) begin
      n_bad++;
      $display("FAIL err_sticky got %b want 1", bus.err);
    end
  endtask

  task automatic test_reset_mid_read();
    send(1'b0, 7, 1'b0, 6, 1'b0);
    send(1'b1, 0, 1'b0, 0, 1'b0);
    bus.block_start = 1'b1;
    @(negedge clk);
    bus.block_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.coef_next = 1'b1;
      @(negedge clk);
      bus.coef_next = 1'b0;
    end
    n_cmp++;
    if ({bus.coef_sign, bus.coef_data} !== 13'd6) begin
      n_bad++;
      $display("FAIL mid_coef10 got %h want 6",
        {bus.coef_sign, bus.coef_data});
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({bus.rl_ready, bus.blk_ready, bus.err} !== 3'b100) begin
      n_bad++;
      $display("FAIL mid_rst_flags got %b want 100",
        {bus.rl_ready, bus.blk_ready, bus.err});
    end
    n_cmp++;
    if (bus.coef_data !== 12'h0) begin
      n_bad++;
      $display("FAIL mid_rst_data got %h want 0",
        bus.coef_data);
    end
    @(negedge clk);
    reset = 1'b0;
    send(1'b0, 3, 1'b1, 2, 1'b0);
    send(1'b1, 0, 1'b0, 0, 1'b0);
    exp_c = '{default: '0};
    exp_c[16] = '{sign: 1'b1, mag: 12'd2};
    read_block();
    for (int i = 0; i < 64; i++) begin
      n_cmp++;
      if (got[i] !== exp_c[i]) begin
        n_bad++;
        $display("FAIL fresh_coef[%0d] got %h want %h",
          i, got[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_softreset();
    send(1'b0, 0, 1'b0, 1, 1'b0);
    send(1'b0, 63, 1'b0, 7, 1'b0);
    send(1'b1, 0, 1'b0, 0, 1'b0);
    n_cmp++;
    if ({bus.err, bus.blk_ready} !== 2'b11) begin
      n_bad++;
      $display("FAIL srst_pre got %b want 11",
        {bus.err, bus.blk_ready});
    end
    softreset = 1'b1;
    @(negedge clk);
    softreset = 1'b0;
    n_cmp++;
    if ({bus.err, bus.blk_ready, bus.rl_ready} !== 3'b001) begin
      n_bad++;
      $display("FAIL srst_post got %b want 001",
        {bus.err, bus.blk_ready, bus.rl_ready});
    end
  endtask

  initial begin
    reset           = 1'b1;
    softreset       = 1'b0;
    bus.rl_valid    = 1'b0;
    bus.rl_eob      = 1'b0;
    bus.rl_run      = '0;
    bus.rl_sign     = 1'b0;
    bus.rl_level    = '0;
    bus.alt_scan    = 1'b0;
    bus.block_start = 1'b0;
    bus.coef_next   = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_zigzag();
    test_alt();
    test_back_to_back();
    test_overflow();
    test_empty();
    test_reset_mid_read();
    test_softreset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/m2vcoefbuf.md
Name: m2vcoefbuf

Overview:
- Coefficient reorder buffer directly upstream of the IDCT stage.
- Accepts run/level pairs from the VLD in scan order and de-scans them (zigzag or alternate scan) into a 64-entry block.
- Serves coefficients in raster order to the IDCT's coef_next pull interface.
- Double-banked: VLD fills one block while the IDCT drains the other.

Parameters:
- COEF_WIDTH, 12, magnitude width of a coefficient (sign carried separately).
- RUN_WIDTH, 6, width of run field.

Ports:
- clk in 1: sole clock.
- reset in 1: asynchronous, active-high reset.
- softreset in 1: synchronous clear, same effect as reset.
- rl_valid in 1: run/level (or EOB) presented.
- rl_ready out 1: buffer can accept a pair this cycle.
- rl_eob in 1: end-of-block marker; run/level ignored when set.
- rl_run in RUN_WIDTH: zero coefficients preceding this one.
- rl_sign in 1: coefficient sign (1 = negative).
- rl_level in COEF_WIDTH: coefficient magnitude.
- alt_scan in 1: scan type, sampled with first accepted pair of each block.
- blk_ready out 1: a complete block is available for reading.
- blk_coded out 1: block has at least one nonzero entry; valid while blk_ready.
- block_start in 1: consumer begins reading the ready block.
- coef_next in 1: consumer advances to next raster coefficient.
- coef_sign out 1: current coefficient sign.
- coef_data out COEF_WIDTH: current coefficient magnitude.
- err out 1: sticky scan-overflow flag.

Behaviour:
- Reset/softreset values:
  - rl_ready = 1; blk_ready = 0; blk_coded = 0; coef_sign = 0; coef_data = 0; err = 0.
  - Both banks empty; wr = rd = bank 0; pos = 0.
- Storage: 2 banks x 64 x (1+COEF_WIDTH), plus a 64-bit written-mask per bank. Unwritten entries read as zero, so no clear cycles are needed.
- Write side:
  - Handshake is rl_valid & rl_ready. rl_ready = !full[wr].
  - Non-EOB pair: p = pos + rl_run, computed 7 bits wide.
    - If p <= 63: write {sign,level} to raster = scan(alt, p); set mask bit; pos <= p + 1.
    - If p > 63: drop the pair, set err, pos <= 64.
  - EOB: full[wr] <= 1; wr toggles; pos <= 0. alt is re-sampled on the next block's first pair.
  - EOB as the first pair of a block: empty block with blk_coded = 0, still delivered as 64 zeros.
- Read side:
  - blk_ready = full[rd]; blk_coded = |mask[rd].
  - block_start while blk_ready: ridx <= 0, active <= 1. Coefficient 0 appears on coef_sign/coef_data at cycle t+1.
  - coef_next while active: ridx++, next coefficient appears at t+1.
  - coef_next at ridx = 63: full[rd] <= 0, mask[rd] <= 0, rd toggles, active <= 0, outputs <= 0.
  - block_start while !blk_ready, or while active: ignored.
  - coef_next while !active: ignored.
- Simultaneous events:
  - EOB on wr bank and release of rd bank in the same cycle: both take effect (per-bank flags).
  - A released bank is writable the next cycle; rl_ready rises the cycle after the final coef_next.
- Reset mid-block (either side) discards all buffered data. err is cleared only by reset or softreset.

Decomposition:
- Package m2vcoefbuf_pkg holds:
  - ZIGZAG_SCAN[64] and ALT_SCAN[64] raster-index constants (ISO 13818-2).
  - COEF_WIDTH and RUN_WIDTH defaults.
  - A coef_t packed struct {sign, mag}.
- Sub-module m2vscan_rom: combinational 1-bit alt + 6-bit scan index to 6-bit raster index.

Test Plan:
- Zigzag: pairs (run0,+5), (run1,-3), EOB; block_start; 64 coef_next → raster0 = +5, raster8 = -3 (scan2 → 8), others 0; blk_coded = 1.
- Alternate scan, same pairs with alt_scan = 1 → raster0 = +5, raster16 = -3; all others 0.
- Back-pressure: write two EOB-terminated blocks without reading → rl_ready = 0. After the 64th coef_next on block A, rl_ready = 1 the next cycle; block B then served with blk_ready = 1.
- Overflow: (run0,+1), then (run63,+7), EOB → err = 1; block reads raster0 = +1, rest 0; err stays 1 across later blocks.
- Empty block: EOB only → blk_ready = 1, blk_coded = 0, 64 zero coefficients.
- Reset mid-read: assert reset after the 10th coef_next → blk_ready = 0, coef_data = 0, rl_ready = 1; a fresh block afterwards decodes correctly.
